// File: rtl/sram_responder.sv
// On-chip stand-in for the SLC-3 external 1Mx16 SRAM: strobe decode, latency-programmable reads, idle-time word loader.
// Optional macro SRAM_CLEAR_ON_RESET_EN: reset zeroes every word through the CLEAR state (Busy high meanwhile).
module sram_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    input  logic [19:0]       ADDR,
    input  logic [15:0]       Data_in,
    output logic [15:0]       Data_out,
    output logic              Data_oe,
    input  logic              Load_valid,
    input  logic [ADDR_W-1:0] Load_addr,
    input  logic [15:0]       Load_data,
    output logic              Load_ready,
    output logic              Busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [2:0]  LAT3  = 3'(READ_LAT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
`ifdef SRAM_CLEAR_ON_RESET_EN
        , CLEAR  = 2'd3
`endif
    } state_t;

    logic [15:0]       r_mem [0:DEPTH-1];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [15:0]       r_dout;
    logic [15:0]       w_dout_nxt;
    logic              r_doe;
    logic              w_doe_nxt;
`ifdef SRAM_CLEAR_ON_RESET_EN
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_nxt;
`endif

    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr_lo;
    logic [15:0]       w_rd_word;
    logic [15:0]       w_rd_masked;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [15:0]       w_mem_wdata;
    logic [1:0]        w_mem_be;

    // Upper address bits do not select anything; words alias modulo DEPTH.
    if (ADDR_W < 20) begin : g_addr_hi
        logic w_unused_hi;
        assign w_unused_hi = ^ADDR[19:ADDR_W];
    end

    assign w_wr        = ~CE & ~WE;
    assign w_rd        = ~CE & WE & ~OE;
    assign w_addr_lo   = ADDR[ADDR_W-1:0];
    assign w_rd_word   = r_mem[r_addr];
    assign w_rd_masked = {UB ? 8'h00 : w_rd_word[15:8], LB ? 8'h00 : w_rd_word[7:0]};

    assign Data_out   = r_dout;
    assign Data_oe    = r_doe;
    assign Load_ready = ~Reset & (r_state == IDLE) & CE & Load_valid;
`ifdef SRAM_CLEAR_ON_RESET_EN
    assign Busy = (r_state == CLEAR);
`else
    assign Busy = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
`ifdef SRAM_CLEAR_ON_RESET_EN
            r_state    <= CLEAR;
            r_clr_addr <= '0;
`else
            r_state    <= IDLE;
`endif
            r_cnt      <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_doe      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
`ifdef SRAM_CLEAR_ON_RESET_EN
            r_clr_addr <= w_clr_nxt;
`endif
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_dout     <= w_dout_nxt;
            r_doe      <= w_doe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_dout_nxt  = r_dout;
        w_doe_nxt   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = w_addr_lo;
        w_mem_wdata = Data_in;
        w_mem_be    = {~UB, ~LB};
`ifdef SRAM_CLEAR_ON_RESET_EN
        w_clr_nxt   = r_clr_addr;
`endif
        case (r_state)
            IDLE, RD_WAIT, RD_DRIVE: begin
                if (w_wr) begin
                    w_mem_we    = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_rd) begin
                    // A new read or a moved address restarts the latency count.
                    if (r_state == IDLE || w_addr_lo != r_addr) begin
                        w_state_nxt = RD_WAIT;
                        w_addr_nxt  = w_addr_lo;
                        w_cnt_nxt   = 3'd1;
                    end else if (r_state == RD_DRIVE || r_cnt == LAT3) begin
                        w_state_nxt = RD_DRIVE;
                        w_doe_nxt   = 1'b1;
                        w_dout_nxt  = w_rd_masked;
                    end else begin
                        w_cnt_nxt   = r_cnt + 3'd1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    if (Load_ready) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = Load_addr;
                        w_mem_wdata = Load_data;
                        w_mem_be    = 2'b11;
                    end
                end
            end
`ifdef SRAM_CLEAR_ON_RESET_EN
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_addr;
                w_mem_wdata = '0;
                w_mem_be    = 2'b11;
                if (&r_clr_addr) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_clr_nxt   = r_clr_addr + 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_mem_we && !Reset) begin
            if (w_mem_be[0]) r_mem[w_mem_addr][7:0]  <= w_mem_wdata[7:0];
            if (w_mem_be[1]) r_mem[w_mem_addr][15:8] <= w_mem_wdata[15:8];
        end
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- On-chip memory target that sits at the far end of the SLC-3 external memory bus, in place of the off-chip 1Mx16 SRAM.
- Decodes the active-low CE/UB/LB/OE/WE strobes, the 20-bit ADDR and the write data from the CPU side. Returns read data with a programmable latency and a drive-enable for the top-level tristate.
- Includes a word loader port (valid/ready) so the test bench or a boot block can preload programs while the bus is idle.

Parameters:
- ADDR_W, 10, implemented address bits; depth = 2**ADDR_W words; ADDR[19:ADDR_W] ignored, so addresses alias modulo depth.
- READ_LAT, 2, cycles from a sampled read request to valid Data_out; legal range 1..4.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- CE  input  1  chip enable, active low
- UB  input  1  upper byte enable, active low
- LB  input  1  lower byte enable, active low
- OE  input  1  output enable, active low
- WE  input  1  write enable, active low
- ADDR  input  20  word address
- Data_in  input  16  write data from the bus
- Data_out  output  16  read data toward the bus
- Data_oe  output  1  high when Data_out must drive the bus
- Load_valid  input  1  loader word available
- Load_addr  input  ADDR_W  loader word address
- Load_data  input  16  loader word
- Load_ready  output  1  loader word accepted this cycle
- Busy  output  1  high while the clear sequence runs

Behaviour:
- All inputs are sampled on rising Clk. Reset has priority over everything.
- Reset values:
  - Data_out = 0, Data_oe = 0, Load_ready = 0.
  - Busy = 1 if SRAM_CLEAR_ON_RESET_EN is defined, else 0.
  - Latency counter = 0.
- FSM states: CLEAR, IDLE, RD_WAIT, RD_DRIVE.
- Request decode, evaluated in priority order each cycle:
  - WR: CE=0 and WE=0. WE wins over OE when both are low.
  - RD: CE=0, WE=1, OE=0.
  - Otherwise no bus request.
- Write:
  - In IDLE, RD_WAIT or RD_DRIVE, a sampled WR writes mem[ADDR mod depth] at that edge.
  - Byte lanes are gated: LB=0 writes [7:0], UB=0 writes [15:8]. UB=LB=1 writes nothing.
  - Each held cycle rewrites the same value.
  - A WR aborts any read: next state IDLE, Data_oe=0 on the following cycle.
- Read:
  - IDLE + RD sampled at edge t: capture address, go to RD_WAIT, counter = 1.
  - In RD_WAIT, while RD stays asserted with an unchanged address, the counter increments. When counter = READ_LAT, at edge t+READ_LAT:
    - Data_out = mem[captured address], with disabled byte lanes forced to 0.
    - Data_oe = 1; go to RD_DRIVE.
  - RD_DRIVE: Data_oe stays 1 and Data_out tracks the captured word while RD is held with the same address.
  - RD deasserted in RD_WAIT or RD_DRIVE: go to IDLE; Data_oe = 0 at the next edge.
  - Address change while RD is held: re-capture, restart the counter at 1 (RD_WAIT), Data_oe = 0.
- Loader:
  - Load_ready = 1 only in IDLE when CE=1 (bus idle) and Load_valid=1. Combinational from the registered state and inputs.
  - On a ready&valid edge: mem[Load_addr] = Load_data, all 16 bits.
  - Bus requests block the loader: Load_ready = 0 whenever CE=0.
  - Load_valid may stay high across cycles; each accepted cycle writes.
- CLEAR:
  - Writes 0 to address k at cycle k for k = 0..depth-1. Busy = 1 throughout.
  - Bus requests are ignored: Data_oe = 0, no writes. Load_ready = 0.
  - After the last word, enter IDLE; Busy falls on the same edge.
- Reset mid-read or mid-clear: the next state is CLEAR or IDLE (per the macro), Data_oe = 0 immediately after the edge, and the clear restarts at address 0.

Optional Feature:
- Macro SRAM_CLEAR_ON_RESET_EN.
- Defined: reset enters CLEAR and zeroes all 2**ADDR_W words (Busy high for exactly 2**ADDR_W cycles).
- Undefined: reset enters IDLE directly; memory contents survive reset; Busy is tied to 0; the CLEAR state is not synthesized.

Test Plan:
- Loader write then bus read:
  - Stimulus: load 0x3000 <- 0x1234 (ADDR_W=16); then CE=0, OE=0, WE=1, UB=LB=0, ADDR=0x03000 at edge t.
  - Response: Data_oe=0 at t+1; Data_oe=1 and Data_out=0x1234 at t+2 (READ_LAT=2).
- Byte-masked write:
  - Stimulus: address 5 holds 0xAAAA; write Data_in=0x55CC with UB=1, LB=0; then read address 5.
  - Response: 0xAACC.
- Read abort and restart:
  - Stimulus: RD to address 1 for one cycle, then CE=1; then RD to address 2 held, with address changed to 3 after one cycle.
  - Response: no Data_oe pulse during the aborted read; Data_out=mem[3] exactly READ_LAT cycles after the address change.
- Aliasing and WE/OE priority:
  - Stimulus: ADDR_W=10; CE=0, WE=0, OE=0, ADDR=0x00400, Data_in=0xBEEF; then read ADDR=0x00000.
  - Response: no Data_oe during the write; the read returns 0xBEEF.
- Loader blocking:
  - Stimulus: Load_valid=1 while CE=0 for 3 cycles, then CE=1.
  - Response: Load_ready=0 for 3 cycles, then 1; the word is written once per accepted cycle.
- Clear (macro defined):
  - Stimulus: memory written to 0xFFFF; assert Reset for 1 cycle.
  - Response: Busy high for 1024 cycles (ADDR_W=10); afterwards a read of address 0x3FF returns 0x0000.
